sodor_mem_arbiter: RTL and testbench

Shares one single-ported, variable-latency backing memory between the Sodor core's instruction-fetch port and its data port. Sits between the core's imem/dmem interfaces and the fuzzing memory model. Keeps exactly one transaction outstanding. Data requests have priority, but a starvation guard keeps fetch moving. A response timeout stops a hung backing model from deadlocking the core.

---
 rtl/sodor_mem_arbiter_if.sv | 49 ++++
 rtl/sodor_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_sodor_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sodor_mem_arbiter_if.sv
// Bundle of the fetch, data and backing-memory handshakes around sodor_mem_arbiter.
// The slave modport is the arbiter's view; master is the core plus memory model side.
interface sodor_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;

    logic              d_req_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_wen;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;

    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_req_wen;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              timeout_err;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_valid, d_req_addr, d_req_wdata, d_req_wen,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wen,
        input  mem_resp_valid, mem_resp_data,
        output timeout_err
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output d_req_valid, d_req_addr, d_req_wdata, d_req_wen,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wen,
        output mem_resp_valid, mem_resp_data,
        input  timeout_err
    );
endinterface

// File: rtl/sodor_mem_arbiter.sv
// Shares one variable-latency backing memory between Sodor fetch and data ports,
// one transaction in flight, data-first with a fetch starvation guard and a response timeout.
module sodor_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input logic                clk,
    input logic                rst_n,
    sodor_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [WW-1:0]     WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] NOP_INSN   = DATA_W'(32'h0000_0013);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    logic [SW-1:0]     starve_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wen;
    logic              req_pulse;
    logic              if_rv;
    logic [DATA_W-1:0] if_rd;
    logic              d_rv;
    logic [DATA_W-1:0] d_rd;
    logic              err;
    logic              grant_if;
    logic              grant_d;
    logic              done;
    logic              timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Readies are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n && bus.if_req_valid && (!bus.d_req_valid || starve_cnt == STARVE_LIM))
                    grant_if = 1'b1;
                else if (rst_n && bus.d_req_valid)
                    grant_d = 1'b1;
                if (grant_if || grant_d) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    done = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
                if (done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A response is accepted in any WAIT cycle, including the one carrying mem_req_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_IF;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wen    <= 1'b0;
            req_pulse  <= 1'b0;
            if_rv      <= 1'b0;
            if_rd      <= '0;
            d_rv       <= 1'b0;
            d_rd       <= '0;
            err        <= 1'b0;
        end else begin
            req_pulse <= 1'b0;
            if_rv     <= 1'b0;
            d_rv      <= 1'b0;
            if (grant_if) begin
                owner      <= OWN_IF;
                req_addr   <= bus.if_req_addr;
                req_wdata  <= '0;
                req_wen    <= 1'b0;
                req_pulse  <= 1'b1;
                wait_cnt   <= '0;
                starve_cnt <= '0;
            end else if (grant_d) begin
                owner     <= OWN_D;
                req_addr  <= bus.d_req_addr;
                req_wdata <= bus.d_req_wdata;
                req_wen   <= bus.d_req_wen;
                req_pulse <= 1'b1;
                wait_cnt  <= '0;
                if (bus.if_req_valid && starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + SW'(1);
            end
            if (state == ST_WAIT && !done) wait_cnt <= wait_cnt + WW'(1);
            if (done) begin
                if (owner == OWN_IF) begin
                    if_rv <= 1'b1;
                    if_rd <= timed_out ? NOP_INSN : bus.mem_resp_data;
                end else begin
                    d_rv <= 1'b1;
                    d_rd <= (timed_out || req_wen) ? '0 : bus.mem_resp_data;
                end
                if (timed_out) err <= 1'b1;
            end
        end
    end

    assign bus.if_req_ready  = grant_if;
    assign bus.d_req_ready   = grant_d;
    assign bus.mem_req_valid = req_pulse;
    assign bus.mem_req_addr  = req_addr;
    assign bus.mem_req_wdata = req_wdata;
    assign bus.mem_req_wen   = req_wen;
    assign bus.if_resp_valid = if_rv;
    assign bus.if_resp_data  = if_rd;
    assign bus.d_resp_valid  = d_rv;
    assign bus.d_resp_data   = d_rd;
    assign bus.timeout_err   = err;
endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Scoreboard bench for sodor_mem_arbiter: a negedge monitor predicts readies, mem requests and
// responses from a transaction-level model and also plays the variable-latency backing memory.
module tb_sodor_mem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;
    localparam int SILENT     = -1;
    localparam int RANDOM_LAT = -2;

    typedef struct {
        logic        is_fetch;
        logic [31:0] data;
        logic        timed_out;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
    } mreq_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    resp_t       exp_q[$];
    mreq_t       req_q[$];
    int          lat_q[$];
    logic        grant_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] backing [logic [31:0]];

    bit          mon_en      = 0;
    bit          busy        = 0;
    bit          req_due     = 0;
    bit          model_err   = 0;
    bit          log_grants  = 0;
    int          starve      = 0;
    int          force_lat   = RANDOM_LAT;
    int          n_accept    = 0;
    int          n_resp      = 0;
    int          cd          = -1;
    logic [31:0] r_addr      = '0;
    logic [31:0] r_wdata     = '0;
    logic        r_wen       = 1'b0;
    bit          r_commit    = 0;

    sodor_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sodor_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] memDefault(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] readRef(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : memDefault(a);
    endfunction

    function automatic int pickLatency();
        int r;
        r = $urandom_range(0, 31);
        if (r < 20) return r % 4;
        if (r < 23) return TIMEOUT - 1;
        if (r < 26) return TIMEOUT;
        if (r < 28) return SILENT;
        return $urandom_range(4, 6);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic dv,
                                 input logic [31:0] da, input logic [31:0] dw, input logic dwen);
        @(posedge clk);
        #1;
        bus.if_req_valid = iv;
        bus.if_req_addr  = ia;
        bus.d_req_valid  = dv;
        bus.d_req_addr   = da;
        bus.d_req_wdata  = dw;
        bus.d_req_wen    = dwen;
    endtask

    task automatic waitDrain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        checkOutput("drain", exp_q.size(), 0);
    endtask

    // Monitor and backing memory: responses, then readies, then mem request, then acceptance.
    initial forever begin : monitor
        resp_t e;
        mreq_t m;
        logic  exp_ifr, exp_dr, iv, dv;
        int    lat, rlat;
        @(negedge clk);
        if (mon_en) begin
            if (bus.if_resp_valid || bus.d_resp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_resp", {bus.if_resp_valid, bus.d_resp_valid}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    n_resp++;
                    if (e.timed_out) model_err = 1;
                    checkOutput("resp_port", {bus.if_resp_valid, bus.d_resp_valid},
                                e.is_fetch ? 2'b10 : 2'b01);
                    checkOutput("resp_data", e.is_fetch ? bus.if_resp_data : bus.d_resp_data, e.data);
                    checkOutput("resp_cycle", cyc, e.due);
                    checkOutput("timeout_err", bus.timeout_err, model_err);
                end
                busy = 0;
            end

            iv = bus.if_req_valid;
            dv = bus.d_req_valid;
            if (busy)          {exp_ifr, exp_dr} = 2'b00;
            else if (iv && dv) {exp_ifr, exp_dr} = (starve >= STARVE_MAX) ? 2'b10 : 2'b01;
            else               {exp_ifr, exp_dr} = {iv, dv};
            checkOutput("readies", {bus.if_req_ready, bus.d_req_ready}, {exp_ifr, exp_dr});
            checkOutput("ready_excl", bus.if_req_ready & bus.d_req_ready, 1'b0);
            if (log_grants && iv && bus.if_req_ready) grant_q.push_back(1'b1);
            else if (log_grants && dv && bus.d_req_ready) grant_q.push_back(1'b0);

            checkOutput("mem_req_valid", bus.mem_req_valid, req_due);
            if (req_due && req_q.size() > 0) begin
                m = req_q.pop_front();
                if (bus.mem_req_valid) begin
                    checkOutput("mem_req_addr", bus.mem_req_addr, m.addr);
                    checkOutput("mem_req_wdata", bus.mem_req_wdata, m.wdata);
                    checkOutput("mem_req_wen", bus.mem_req_wen, m.wen);
                end
            end

            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = $urandom();
            if (bus.mem_req_valid && lat_q.size() > 0) begin
                rlat     = lat_q.pop_front();
                cd       = rlat;
                r_addr   = bus.mem_req_addr;
                r_wdata  = bus.mem_req_wdata;
                r_wen    = bus.mem_req_wen;
                r_commit = (rlat >= 0 && rlat < TIMEOUT);
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                bus.mem_resp_valid = 1'b1;
                if (r_wen) begin
                    if (r_commit) backing[r_addr] = r_wdata;
                end else begin
                    bus.mem_resp_data = backing.exists(r_addr) ? backing[r_addr] : memDefault(r_addr);
                end
                cd = -1;
            end

            req_due = 0;
            if (exp_ifr || exp_dr) begin
                lat         = (force_lat == RANDOM_LAT) ? pickLatency() : force_lat;
                e.is_fetch  = exp_ifr;
                e.timed_out = (lat < 0 || lat >= TIMEOUT);
                e.due       = e.timed_out ? cyc + TIMEOUT + 1 : cyc + 2 + lat;
                if (exp_ifr) begin
                    m.addr  = bus.if_req_addr;
                    m.wdata = '0;
                    m.wen   = 1'b0;
                    e.data  = e.timed_out ? 32'h0000_0013 : readRef(m.addr);
                    starve  = 0;
                end else begin
                    m.addr  = bus.d_req_addr;
                    m.wdata = bus.d_req_wdata;
                    m.wen   = bus.d_req_wen;
                    if (m.wen) begin
                        e.data = '0;
                        if (!e.timed_out) ref_mem[m.addr] = m.wdata;
                    end else begin
                        e.data = e.timed_out ? 32'h0 : readRef(m.addr);
                    end
                    if (iv && starve < STARVE_MAX) starve++;
                end
                exp_q.push_back(e);
                req_q.push_back(m);
                lat_q.push_back(lat);
                busy    = 1;
                req_due = 1;
                n_accept++;
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int k;
        bus.if_req_valid   = 1'b0;
        bus.if_req_addr    = '0;
        bus.d_req_valid    = 1'b0;
        bus.d_req_addr     = '0;
        bus.d_req_wdata    = '0;
        bus.d_req_wen      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_flags", {bus.if_req_ready, bus.d_req_ready, bus.if_resp_valid, bus.d_resp_valid,
                                  bus.mem_req_valid, bus.mem_req_wen, bus.timeout_err}, '0);
        checkOutput("rst_mem_addr", bus.mem_req_addr, '0);
        checkOutput("rst_mem_wdata", bus.mem_req_wdata, '0);
        checkOutput("rst_resp_data", {bus.if_resp_data, bus.d_resp_data}, '0);
        rst_n  = 1'b1;
        mon_en = 1;

        $display("[TB] zero-latency fetch");
        backing[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        force_lat = 0;
        applyStimulus(1'b1, 32'h100, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        waitDrain(50);

        $display("[TB] write acknowledge");
        force_lat = 3;
        applyStimulus(1'b0, '0, 1'b1, 32'h20, 32'h1234_5678, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        waitDrain(50);

        $display("[TB] starvation guard");
        force_lat = 0;
        grant_q.delete();
        log_grants = 1;
        k = 0;
        while (grant_q.size() < 10 && k < 100) begin
            applyStimulus(1'b1, 32'h40, 1'b1, 32'h80, '0, 1'b0);
            k++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        log_grants = 0;
        waitDrain(50);
        checkOutput("grant_count_ok", grant_q.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < grant_q.size(); i++)
            checkOutput($sformatf("grant_%0d", i), grant_q[i], (i % 5) == 4);

        $display("[TB] timeout with late response");
        force_lat = TIMEOUT + 3;
        applyStimulus(1'b1, 32'h200, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        waitDrain(50);
        repeat (10) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("timeout_sticky", bus.timeout_err, 1'b1);

        $display("[TB] reset during WAIT");
        force_lat = SILENT;
        applyStimulus(1'b1, 32'h300, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        checkOutput("rst_mid_flags", {bus.if_req_ready, bus.d_req_ready, bus.if_resp_valid, bus.d_resp_valid,
                                      bus.mem_req_valid, bus.mem_req_wen, bus.timeout_err}, '0);
        checkOutput("rst_mid_mem", {bus.mem_req_addr, bus.mem_req_wdata}, '0);
        checkOutput("rst_mid_data", {bus.if_resp_data, bus.d_resp_data}, '0);
        exp_q.delete();
        req_q.delete();
        lat_q.delete();
        busy = 0; req_due = 0; model_err = 0; starve = 0; cd = -1;
        n_accept = 0; n_resp = 0;
        bus.mem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1;
        repeat (4) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        force_lat = 1;
        applyStimulus(1'b1, 32'h300, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        waitDrain(50);
        checkOutput("post_reset_resp", n_resp, 1);

        $display("[TB] randomized traffic");
        force_lat = RANDOM_LAT;
        for (int i = 0; i < 10000; i++)
            applyStimulus($urandom_range(0, 1), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                          $urandom_range(0, 1), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                          $urandom(), $urandom_range(0, 1));
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        waitDrain(200);
        checkOutput("accept_vs_resp", n_resp, n_accept);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
